// File: rtl/program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Loads a program into instruction memory, zero-fills the rest,
//            then runs the core until it halts or its cycle budget expires.
// Revision : 1.0
// ============================================================================
module program_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic [CNT_WIDTH-1:0]  run_cycles,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [31:0]           cpu_pc,
    output logic                  cpu_reset,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  done,
    output logic                  halted,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FILL = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0]   c_depth_len = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_len;
    logic [CNT_WIDTH-1:0]    r_budget;
    logic [CNT_WIDTH-1:0]    r_cycle_count;
    logic [31:0]             r_pc_prev;
    logic                    r_halted;
    logic                    r_timeout;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;

    logic [ADDR_WIDTH:0]     w_len_clamped;
    logic                    w_start_seq;
    logic                    w_accept;
    logic                    w_load_last;
    logic                    w_fill_last;
    logic [CNT_WIDTH-1:0]    w_count_inc;
    logic                    w_halt;
    logic                    w_budget_hit;

    assign w_len_clamped = (prog_len > c_depth_len) ? c_depth_len : prog_len;
    assign w_start_seq   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept      = (r_state == ST_LOAD) && s_valid;
    assign w_load_last   = ({1'b0, r_addr} == (r_len - 1'b1));
    assign w_fill_last   = (r_addr == c_last_addr);
    assign w_count_inc   = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
    // The first RUN cycle has no valid previous PC, so halt is masked there.
    assign w_halt        = (r_cycle_count != '0) && (cpu_pc == r_pc_prev);
    assign w_budget_hit  = (r_budget != '0) && (w_count_inc == r_budget);

    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        cpu_reset    = 1'b1;
        cpu_run      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_seq) begin
                    w_state_next = (w_len_clamped == '0) ? ST_FILL : ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_accept && w_load_last) begin
                    w_state_next = (r_len == c_depth_len) ? ST_RUN : ST_FILL;
                end
            end
            ST_FILL: begin
                busy = 1'b1;
                if (w_fill_last) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_reset = 1'b0;
                cpu_run   = 1'b1;
                busy      = 1'b1;
                if (w_halt || w_budget_hit) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (w_start_seq) begin
                    w_state_next = (w_len_clamped == '0) ? ST_FILL : ST_LOAD;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_len         <= '0;
            r_budget      <= '0;
            r_cycle_count <= '0;
            r_pc_prev     <= '0;
            r_halted      <= 1'b0;
            r_timeout     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_seq) begin
                        r_len         <= w_len_clamped;
                        r_budget      <= run_cycles;
                        r_addr        <= '0;
                        r_cycle_count <= '0;
                        r_halted      <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= s_data;
                        // A full-length program ends on the last address; never wrap.
                        if (!(w_load_last && (r_len == c_depth_len))) begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_addr;
                    r_mem_wdata <= '0;
                    if (!w_fill_last) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cycle_count <= w_count_inc;
                    r_pc_prev     <= cpu_pc;
                    if (w_halt) begin
                        r_halted <= 1'b1;
                    end else if (w_budget_hit) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign halted      = r_halted;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Directed vector bench for program_loader with a toy PC model.
// Revision : 1.0
// ============================================================================
module tb_program_loader;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   prog_len;
    logic [CW-1:0] run_cycles;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [31:0]   cpu_pc;
    logic          cpu_reset;
    logic          cpu_run;
    logic          busy;
    logic          done;
    logic          halted;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    program_loader #(.DATA_WIDTH(DW), .MEM_DEPTH(256), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
        .run_cycles(run_cycles), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_pc(cpu_pc), .cpu_reset(cpu_reset),
        .cpu_run(cpu_run), .busy(busy), .done(done), .halted(halted),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Toy core: PC steps by 4 each enabled cycle and sticks at the halt PC (j .).
    logic [31:0] cpu_halt_pc = 32'hFFFF_FFFF;
    always @(posedge clk or negedge reset) begin
        if (!reset)                                cpu_pc <= '0;
        else if (cpu_reset)                        cpu_pc <= '0;
        else if (cpu_run && cpu_pc != cpu_halt_pc) cpu_pc <= cpu_pc + 32'd4;
    end

    int   q_addr[$];
    logic [DW-1:0] q_data[$];
    bit   q_run[$];
    always @(negedge clk) begin
        if (mem_we) begin
            q_addr.push_back(int'(mem_addr));
            q_data.push_back(mem_wdata);
            q_run.push_back(cpu_run);
        end
    end

    typedef struct {
        int len; int budget; bit has_halt; int hw; bit tog;
        int ed; bit eh; bit et; int ec;
    } vec_t;
    vec_t vecs[8];

    int n_vec  = 0;
    int n_miss = 0;

    function automatic logic [DW-1:0] pat(int i);
        return {16'hA5C3, 16'(i)};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(int len, int budget);
        @(negedge clk);
        q_addr.delete(); q_data.delete(); q_run.delete();
        prog_len   = (AW+1)'(len);
        run_cycles = CW'(budget);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic feed(int n, bit tog);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 4000) begin
            s_valid = tog ? ~s_valid : 1'b1;
            s_data  = pat(i);
            if (s_valid && s_ready) i++;
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        check("feed_words", 64'(i), 64'(n));
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic check_writes(int nd);
        int bad = 0;
        int runs = 0;
        check("write_count", 64'(q_addr.size()), 64'd256);
        foreach (q_addr[k]) begin
            if (q_addr[k] != k) bad++;
            if (q_data[k] !== ((k < nd) ? pat(k) : '0)) bad++;
            if (q_run[k]) begin
                runs++;
                if (k != q_addr.size() - 1) bad++;
            end
        end
        check("write_content", 64'(bad), 64'd0);
        check("last_write_in_run", 64'(runs), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        cpu_halt_pc = v.has_halt ? 32'(v.hw * 4) : 32'hFFFF_FFFF;
        do_start(v.len, v.budget);
        feed((v.len > 256) ? 256 : v.len, v.tog);
        wait_done();
        check("busy_done", 64'(busy), 64'd0);
        check("cpu_run_done", 64'(cpu_run), 64'd0);
        check("cpu_reset_done", 64'(cpu_reset), 64'd0);
        check("halted", 64'(halted), 64'(v.eh));
        check("timeout", 64'(timeout), 64'(v.et));
        check("cycle_count", 64'(cycle_count), 64'(v.ec));
        check_writes(v.ed);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        //        len  budget halt hw tog  data  h  t  count
        vecs[0] = '{18,  200,  1, 17, 0,   18,  1, 0, 19};
        vecs[1] = '{10,   50,  0,  0, 0,   10,  0, 1, 50};
        vecs[2] = '{18,    0,  1, 17, 1,   18,  1, 0, 19};
        vecs[3] = '{300,  30,  1,  5, 0,  256,  1, 0,  7};
        vecs[4] = '{0,     7,  1,  6, 0,    0,  0, 1,  7};
        vecs[5] = '{4,     4,  1,  2, 0,    4,  1, 0,  4};
        vecs[6] = '{3,     1,  1,  0, 0,    3,  0, 1,  1};
        vecs[7] = '{256,   0,  1,  0, 1,  256,  1, 0,  2};

        reset = 1'b0; start = 1'b0; prog_len = '0; run_cycles = '0;
        s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_cpu_run", 64'(cpu_run), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_flags", 64'({halted, timeout}), 64'd0);
        check("rst_count", 64'(cycle_count), 64'd0);
        check("rst_mem", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Abort during FILL, then a fresh sequence must complete normally.
        cpu_halt_pc = 32'hFFFF_FFFF;
        do_start(0, 0);
        repeat (20) @(negedge clk);
        check("fill_busy", 64'(busy), 64'd1);
        check("fill_we", 64'(mem_we), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_cpu_reset", 64'(cpu_reset), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_flags", 64'({halted, timeout}), 64'd0);
        check("abort_we", 64'(mem_we), 64'd0);
        check("abort_count", 64'(cycle_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_vec(vecs[0]);

        // start during RUN is ignored; start in DONE restarts from a cleared count.
        cpu_halt_pc = 32'hFFFF_FFFF;
        do_start(4, 40);
        feed(4, 1'b0);
        cyc = 0;
        while (!cpu_run && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_run", 64'(cpu_run), 64'd1);
        prog_len = 9'd2; run_cycles = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run_start_ignored", 64'(cpu_run), 64'd1);
        wait_done();
        check("ign_timeout", 64'(timeout), 64'd1);
        check("ign_halted", 64'(halted), 64'd0);
        check("ign_count", 64'(cycle_count), 64'd40);
        q_addr.delete(); q_data.delete(); q_run.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_ready", 64'(s_ready), 64'd1);
        check("restart_done", 64'(done), 64'd0);
        check("restart_count", 64'(cycle_count), 64'd0);
        s_valid = 1'b1; s_data = pat(0);
        @(negedge clk);
        check("lat_we", 64'(mem_we), 64'd1);
        check("lat_addr", 64'(mem_addr), 64'd0);
        check("lat_data", 64'(mem_wdata), 64'(pat(0)));
        s_data = pat(1);
        @(negedge clk);
        s_valid = 1'b0;
        check("lat_addr1", 64'(mem_addr), 64'd1);
        wait_done();
        check("restart_timeout", 64'(timeout), 64'd1);
        check("restart_cycles", 64'(cycle_count), 64'd5);
        check_writes(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
